fft_in_packer: RTL and testbench
================================

Name: fft_in_packer

Overview:
- Transmit-side framer that drives the FFT input interface.
- Accepts one complex sample per cycle through a valid/ready handshake. Collects a full N-point frame, then replays it to the FFT as N/NUM contiguous beats, NUM samples per beat, with a single qualifying valid.
- Guarantees the FFT's requirement: valid held high for exactly N/NUM consecutive cycles per frame, plus a minimum idle gap between frames.

Parameters:
- IN_WIDTH, 9, sample width per component, signed <3.6> two's complement.
- NUM, 16, samples per output beat (lanes).
- N, 512, points per frame; must be a multiple of NUM. BEATS = N/NUM = 32.
- GAP_CYCLES, 2, minimum idle cycles between the last beat of one burst and the first accepted input of the next frame; minimum 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  packer can accept a sample this cycle.
- in_i  input  IN_WIDTH  signed in-phase sample.
- in_q  input  IN_WIDTH  signed quadrature sample.
- valid_out  output  1  beat valid; connects to FFT valid_in.
- dout_i  output  NUM x IN_WIDTH (unpacked [0:NUM-1])  in-phase lanes; connects to FFT din_i.
- dout_q  output  NUM x IN_WIDTH (unpacked [0:NUM-1])  quadrature lanes; connects to FFT din_q.
- frame_start  output  1  one-cycle pulse coincident with beat 0 of each burst.
- busy  output  1  high in BURST or GAP state.

Behaviour:
- Reset (rstn=0 at a rising edge):
  - state=FILL, all counters 0, valid_out=0, frame_start=0, busy=0.
  - dout_i/dout_q all lanes 0; in_ready=1 on the first cycle after reset release.
  - Frame storage contents are don't-care.
  - Reset mid-FILL discards the partial frame. Reset mid-BURST truncates the burst: valid_out=0 on the next cycle.
- Storage: BEATS rows x NUM lanes x 2 components, registers or inferred RAM. Sample k of a frame (k = accept order, 0-based) is stored at row k/NUM, lane k%NUM.
- Beat ordering: beat b lane j = sample b*NUM+j. Lane 0 is the earliest sample of the beat.
- States:
  - FILL: in_ready=1. A sample transfers when in_valid && in_ready.
    - lane_cnt increments per transfer and wraps at NUM-1, incrementing row_cnt.
    - in_valid low holds all counters; no timeout.
    - Transfer of sample N-1 -> BURST on the next cycle; counters cleared.
  - BURST: in_ready=0, busy=1.
    - Registered outputs: valid_out=1 for exactly BEATS consecutive cycles, rows 0..BEATS-1 in order.
    - frame_start=1 with row 0 only.
    - After the row BEATS-1 cycle -> GAP.
  - GAP: in_ready=0, busy=1, valid_out=0.
    - Stays GAP_CYCLES cycles, then -> FILL.
- Latency:
  - Sample N-1 accepted at edge t -> valid_out=1 and frame_start=1 on the cycle after edge t+1.
  - First accepted sample of the next frame is no earlier than BEATS+GAP_CYCLES cycles after beat 0.
- Outputs when valid_out=0: dout_i/dout_q forced to 0. No X or stale data toward the FFT.
- Width rule: samples pass bit-exact; no rounding, saturation or sign change.
- in_valid while in_ready=0: ignored; the sample is not consumed. The upstream must hold it.
- Next-frame data cannot overwrite the burst in progress, since in_ready stays low through BURST.
- Single-buffered: throughput is N samples per (N + BEATS + GAP_CYCLES) cycles.

Test Plan:
- Ramp frame: 512 contiguous samples, in_i=k-256, in_q=255-k.
  -> 32 consecutive valid_out cycles.
  -> Beat b lane j: dout_i = 16b+j-256, dout_q = 255-16b-j.
  -> frame_start only on beat 0; result matches the frame-file reader's expected dump line for line.
- Bubbly input: in_valid toggled on a pseudo-random 50% pattern.
  -> Same beat contents as the ramp test; still exactly 32 back-to-back valid_out cycles with no holes.
- Back-pressure: in_valid held 1 continuously.
  -> in_ready=0 for 32+GAP_CYCLES (34) cycles after the 512th transfer.
  -> No sample lost or duplicated; second-frame beat 0 equals sample 512.
- Signed extremes: frame alternating -256/+255 on both components.
  -> Outputs bit-exact, 9'h100/9'h0FF.
  -> dout=0 on every cycle with valid_out=0.
- Reset mid-FILL at sample 200, then a fresh 512-sample frame.
  -> The burst contains only the fresh frame. No valid_out before its 512th sample is accepted.
- Reset at burst beat 10.
  -> valid_out=0 the following cycle; busy=0; in_ready=1.
  -> Next full frame produces a complete 32-beat burst.

Source files
------------

// File: rtl/fft_in_packer_if.sv
// Sample-in / beat-out bundle between the upstream source, the packer and the FFT.
// slave is the packer's view; master is the upstream/FFT-side environment view.
interface fft_in_packer_if #(
    parameter int IN_WIDTH = 9,
    parameter int NUM      = 16
);
    logic                       in_valid;
    logic                       in_ready;
    logic signed [IN_WIDTH-1:0] in_i;
    logic signed [IN_WIDTH-1:0] in_q;
    logic                       valid_out;
    logic                       frame_start;
    logic signed [IN_WIDTH-1:0] dout_i [0:NUM-1];
    logic signed [IN_WIDTH-1:0] dout_q [0:NUM-1];

    modport slave (
        input  in_valid, in_i, in_q,
        output in_ready, valid_out, frame_start, dout_i, dout_q
    );

    modport master (
        output in_valid, in_i, in_q,
        input  in_ready, valid_out, frame_start, dout_i, dout_q
    );
endinterface

// File: rtl/fft_in_packer.sv
// Collects N complex samples, then replays them as N/NUM back-to-back NUM-lane beats; beat 0 appears two edges after the last accept.
// in_ready is low from the last accept of a frame through the burst and the idle gap; upstream must hold its sample meanwhile.
module fft_in_packer #(
    parameter int IN_WIDTH   = 9,
    parameter int NUM        = 16,
    parameter int N          = 512,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    fft_in_packer_if.slave   bus,
    output logic             busy
);
    localparam int BEATS = N / NUM;
    localparam int LW    = (NUM > 1)        ? $clog2(NUM)        : 1;
    localparam int RW    = (BEATS > 1)      ? $clog2(BEATS)      : 1;
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {FILL, BURST, GAP} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    lane_cnt_q, lane_cnt_d;
    logic [RW-1:0]    row_cnt_q, row_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             valid_q, valid_d;
    logic             frame_start_q, frame_start_d;
    logic signed [IN_WIDTH-1:0] dout_i_q [0:NUM-1];
    logic signed [IN_WIDTH-1:0] dout_i_d [0:NUM-1];
    logic signed [IN_WIDTH-1:0] dout_q_q [0:NUM-1];
    logic signed [IN_WIDTH-1:0] dout_q_d [0:NUM-1];

    // Frame store: row = sample / NUM, lane = sample % NUM. Contents need no reset.
    logic signed [IN_WIDTH-1:0] mem_i [0:BEATS-1][0:NUM-1];
    logic signed [IN_WIDTH-1:0] mem_q [0:BEATS-1][0:NUM-1];

    logic accept;
    assign accept = bus.in_valid && (state_q == FILL);

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_i[row_cnt_q][lane_cnt_q] <= bus.in_i;
            mem_q[row_cnt_q][lane_cnt_q] <= bus.in_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        lane_cnt_d    = lane_cnt_q;
        row_cnt_d     = row_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        valid_d       = 1'b0;
        frame_start_d = 1'b0;
        for (int j = 0; j < NUM; j++) begin
            dout_i_d[j] = '0;
            dout_q_d[j] = '0;
        end
        case (state_q)
            FILL: begin
                if (accept) begin
                    if (lane_cnt_q == LW'(NUM - 1)) begin
                        lane_cnt_d = '0;
                        if (row_cnt_q == RW'(BEATS - 1)) begin
                            row_cnt_d = '0;
                            state_d   = BURST;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end else begin
                        lane_cnt_d = lane_cnt_q + 1'b1;
                    end
                end
            end
            BURST: begin
                // Outputs are registered, so the last beat is visible during the first GAP cycle.
                valid_d       = 1'b1;
                frame_start_d = (row_cnt_q == '0);
                for (int j = 0; j < NUM; j++) begin
                    dout_i_d[j] = mem_i[row_cnt_q][j];
                    dout_q_d[j] = mem_q[row_cnt_q][j];
                end
                if (row_cnt_q == RW'(BEATS - 1)) begin
                    row_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                    gap_cnt_d = '0;
                    state_d   = FILL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= FILL;
            lane_cnt_q    <= '0;
            row_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            valid_q       <= 1'b0;
            frame_start_q <= 1'b0;
            for (int j = 0; j < NUM; j++) begin
                dout_i_q[j] <= '0;
                dout_q_q[j] <= '0;
            end
        end else begin
            state_q       <= state_d;
            lane_cnt_q    <= lane_cnt_d;
            row_cnt_q     <= row_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            valid_q       <= valid_d;
            frame_start_q <= frame_start_d;
            for (int j = 0; j < NUM; j++) begin
                dout_i_q[j] <= dout_i_d[j];
                dout_q_q[j] <= dout_q_d[j];
            end
        end
    end

    assign bus.in_ready    = (state_q == FILL);
    assign bus.valid_out   = valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.dout_i      = dout_i_q;
    assign bus.dout_q      = dout_q_q;
    assign busy            = (state_q != FILL);
endmodule

// File: tb/tb_fft_in_packer.sv
// Directed sequence with randomized data/bubbles; expected beats come from a queue of accepted samples.
module tb_fft_in_packer;
    localparam int W     = 9;
    localparam int NUM   = 16;
    localparam int N     = 512;
    localparam int GAP   = 2;
    localparam int BEATS = N / NUM;

    logic clk = 1'b0;
    logic rstn;
    logic busy;

    always #5 clk = ~clk;

    fft_in_packer_if #(.IN_WIDTH(W), .NUM(NUM)) bus ();

    fft_in_packer #(.IN_WIDTH(W), .NUM(NUM), .N(N), .GAP_CYCLES(GAP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave),
        .busy (busy)
    );

    int checks = 0;
    int errors = 0;
    logic signed [W-1:0] mq_i [$];
    logic signed [W-1:0] mq_q [$];
    logic signed [W-1:0] fr_i [N];
    logic signed [W-1:0] fr_q [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_chk(input string tag);
        logic any;
        any = 1'b0;
        for (int j = 0; j < NUM; j++) any = any | (|bus.dout_i[j]) | (|bus.dout_q[j]);
        chk(tag, {31'd0, any}, 32'd0);
    endtask

    // mode 0: ramp, mode 1: alternating extremes, otherwise random
    function automatic logic signed [W-1:0] gen_i(input int mode, input int k);
        if (mode == 0)      return W'(k - 256);
        else if (mode == 1) return (k % 2 == 0) ? 9'sh100 : 9'sh0FF;
        else                return W'($urandom);
    endfunction

    function automatic logic signed [W-1:0] gen_q(input int mode, input int k);
        if (mode == 0)      return W'(255 - k);
        else if (mode == 1) return (k % 2 == 0) ? 9'sh0FF : 9'sh100;
        else                return W'($urandom);
    endfunction

    task automatic send_frame(input int mode, input bit bubbly, input int count, input bit use_held);
        int k = 0;
        int cyc = 0;
        bit v, rdy;
        logic signed [W-1:0] ci, cq;
        ci = use_held ? bus.in_i : gen_i(mode, 0);
        cq = use_held ? bus.in_q : gen_q(mode, 0);
        while (k < count && cyc < count * 8 + 64) begin
            v = bubbly ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.in_valid = v;
            bus.in_i     = ci;
            bus.in_q     = cq;
            rdy = bus.in_ready;
            chk("fill_valid_out", {31'd0, bus.valid_out}, 32'd0);
            zero_chk("fill_dout_zero");
            tick();
            cyc++;
            if (v && rdy) begin
                mq_i.push_back(ci);
                mq_q.push_back(cq);
                k++;
                if (k < count) begin
                    ci = gen_i(mode, k);
                    cq = gen_q(mode, k);
                end
            end
        end
        chk("fill_accept_timeout", k, count);
        bus.in_valid = 1'b0;
    endtask

    // Called on the cycle right after the last accept of a frame.
    task automatic check_burst();
        chk("model_frame_avail", {31'd0, mq_i.size() >= N}, 32'd1);
        for (int k = 0; k < N; k++) begin
            fr_i[k] = (mq_i.size() > 0) ? mq_i.pop_front() : '0;
            fr_q[k] = (mq_q.size() > 0) ? mq_q.pop_front() : '0;
        end
        chk("lead_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("lead_in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("lead_busy", {31'd0, busy}, 32'd1);
        for (int b = 0; b < BEATS; b++) begin
            tick();
            chk("beat_valid_out", {31'd0, bus.valid_out}, 32'd1);
            chk("beat_frame_start", {31'd0, bus.frame_start}, (b == 0) ? 32'd1 : 32'd0);
            chk("beat_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("beat_busy", {31'd0, busy}, 32'd1);
            for (int j = 0; j < NUM; j++) begin
                chk($sformatf("beat%0d_lane%0d_i", b, j), 32'(bus.dout_i[j]), 32'(fr_i[b * NUM + j]));
                chk($sformatf("beat%0d_lane%0d_q", b, j), 32'(bus.dout_q[j]), 32'(fr_q[b * NUM + j]));
            end
        end
        for (int g = 0; g < GAP - 1; g++) begin
            tick();
            chk("gap_valid_out", {31'd0, bus.valid_out}, 32'd0);
            chk("gap_frame_start", {31'd0, bus.frame_start}, 32'd0);
            zero_chk("gap_dout_zero");
            chk("gap_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("gap_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        chk("refill_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("refill_busy", {31'd0, busy}, 32'd0);
        chk("refill_valid_out", {31'd0, bus.valid_out}, 32'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        chk("rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        zero_chk("rst_dout_zero");
        rstn = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        mq_i.delete();
        mq_q.delete();
    endtask

    initial begin
        rstn = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_i = '0;
        bus.in_q = '0;
        do_reset();

        // contiguous ramp
        send_frame(0, 1'b0, N, 1'b0);
        check_burst();

        // ramp with random input bubbles
        send_frame(0, 1'b1, N, 1'b0);
        check_burst();

        // back-pressure: in_valid stays high with the next frame's first sample held
        send_frame(2, 1'b0, N, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_i = gen_i(2, 0);
        bus.in_q = gen_q(2, 0);
        check_burst();
        send_frame(2, 1'b0, N, 1'b1);
        check_burst();

        // signed extremes with bubbles
        send_frame(1, 1'b1, N, 1'b0);
        check_burst();

        // reset mid-fill discards the partial frame
        send_frame(2, 1'b1, 200, 1'b0);
        do_reset();
        send_frame(2, 1'b0, N, 1'b0);
        check_burst();

        // reset at burst beat 10
        send_frame(2, 1'b0, N, 1'b0);
        for (int b = 0; b <= 10; b++) tick();
        chk("beat10_valid_out", {31'd0, bus.valid_out}, 32'd1);
        rstn = 1'b0;
        tick();
        chk("burst_rst_valid_out", {31'd0, bus.valid_out}, 32'd0);
        chk("burst_rst_busy", {31'd0, busy}, 32'd0);
        chk("burst_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        zero_chk("burst_rst_dout_zero");
        rstn = 1'b1;
        mq_i.delete();
        mq_q.delete();
        tick();
        send_frame(2, 1'b1, N, 1'b0);
        check_burst();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
